// File: rtl/mmio_fifo_ctrl.sv
// MMIO window onto a DEPTH x 64-bit ring buffer: DATA push/pop, STATUS, CONTROL.
// Read responses are registered, so latency is one cycle; there is no backpressure.
module mmio_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wr_data,
    output logic        rd_rsp_valid,
    output logic [8:0]  rd_rsp_tid,
    output logic [63:0] rd_rsp_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0022;
    localparam logic [15:0] ADDR_CTRL   = 16'h0024;

    logic [63:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [8:0]       rsp_tid_q, rsp_tid_d;
    logic [63:0]      rsp_dat_q, rsp_dat_d;

    logic        empty, full;
    logic        push_req, pop_req, push_ok, pop_ok;
    logic        ctrl_wr, flush, clr_sticky;
    logic [63:0] status_word, rd_word;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        push_req   = mmio_wr_valid && (mmio_addr == ADDR_DATA);
        pop_req    = mmio_rd_valid && (mmio_addr == ADDR_DATA);
        ctrl_wr    = mmio_wr_valid && (mmio_addr == ADDR_CTRL);
        flush      = ctrl_wr && mmio_wr_data[0];
        clr_sticky = ctrl_wr && mmio_wr_data[1];
        // A pop in the same cycle frees the slot, so a push to a full buffer still lands.
        push_ok    = push_req && (!full || pop_req);
        pop_ok     = pop_req && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_sticky) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (push_req && full && !pop_req) begin
            ovf_d = 1'b1;
        end
        if (pop_req && empty) begin
            udf_d = 1'b1;
        end

        status_word        = '0;
        status_word[15:0]  = 16'(count_q);
        status_word[16]    = empty;
        status_word[17]    = full;
        status_word[18]    = ovf_q;
        status_word[19]    = udf_q;

        rd_word = '0;
        if (mmio_addr == ADDR_DATA) begin
            rd_word = empty ? 64'h0 : mem_q[rd_ptr_q];
        end else if (mmio_addr == ADDR_STATUS) begin
            rd_word = status_word;
        end

        rsp_vld_d = mmio_rd_valid;
        rsp_tid_d = mmio_rd_valid ? mmio_tid : rsp_tid_q;
        rsp_dat_d = mmio_rd_valid ? rd_word  : rsp_dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_tid_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_tid_q <= rsp_tid_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    // Storage is never reset: an empty pop returns zero, so stale entries stay hidden.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= mmio_wr_data;
        end
    end

    assign rd_rsp_valid = rsp_vld_q;
    assign rd_rsp_tid   = rsp_tid_q;
    assign rd_rsp_data  = rsp_dat_q;

endmodule
